// File: rtl/filter_pkg.sv
// Shared constants for the rule filter: rule word layout, control-word bits and FSM states.
package filter_pkg;

   localparam int RULE_WORDS = 6;

   localparam int W_SRC_IP   = 0;
   localparam int W_DST_IP   = 1;
   localparam int W_SRC_MASK = 2;
   localparam int W_DST_MASK = 3;
   localparam int W_PORTS    = 4;
   localparam int W_CTRL     = 5;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_ACT       = 1;
   localparam int CTRL_SPW       = 2;
   localparam int CTRL_DPW       = 3;
   localparam int CTRL_PRW       = 4;
   localparam int CTRL_PROTO_LSB = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MATCH,
      ST_RESOLVE,
      ST_HOLD
   } state_t;

endpackage

// File: rtl/filter_rule_engine_if.sv
// Header-in / decision-out handshake between the header parser, the filter and the send FIFO.
interface filter_rule_engine_if;
   logic        hdr_rd;
   logic        hdr_clear;
   logic [31:0] hdr_src_ip;
   logic [31:0] hdr_dst_ip;
   logic [15:0] hdr_src_port;
   logic [15:0] hdr_dst_port;
   logic [7:0]  hdr_proto;
   logic        m_send;
   logic        m_send_rd;

   modport master (
      output hdr_rd, hdr_clear, hdr_src_ip, hdr_dst_ip, hdr_src_port, hdr_dst_port, hdr_proto,
      input  m_send, m_send_rd
   );

   modport slave (
      input  hdr_rd, hdr_clear, hdr_src_ip, hdr_dst_ip, hdr_src_port, hdr_dst_port, hdr_proto,
      output m_send, m_send_rd
   );
endinterface

// File: rtl/filter_rule_match.sv
// Combinational masked compare of the latched 5-tuple against one rule of the shadow table.
module filter_rule_match
   import filter_pkg::*;
#(
   parameter int DW          = 32,
   parameter int IP_ADDR_LEN = 32,
   parameter int PORT_LEN    = 16
) (
   input  logic [RULE_WORDS*DW-1:0] rule,
   input  logic [IP_ADDR_LEN-1:0]   src_ip,
   input  logic [IP_ADDR_LEN-1:0]   dst_ip,
   input  logic [PORT_LEN-1:0]      src_port,
   input  logic [PORT_LEN-1:0]      dst_port,
   input  logic [7:0]               proto,
   output logic                     hit
);
   logic [DW-1:0]          ctrl;
   logic [IP_ADDR_LEN-1:0] rule_src_ip, rule_dst_ip, src_mask, dst_mask;
   logic [PORT_LEN-1:0]    rule_src_port, rule_dst_port;
   logic                   src_ok, dst_ok, sport_ok, dport_ok, proto_ok;
   logic                   unused_ctrl_bits;

   assign ctrl          = rule[W_CTRL*DW +: DW];
   assign rule_src_ip   = rule[W_SRC_IP*DW +: IP_ADDR_LEN];
   assign rule_dst_ip   = rule[W_DST_IP*DW +: IP_ADDR_LEN];
   assign src_mask      = rule[W_SRC_MASK*DW +: IP_ADDR_LEN];
   assign dst_mask      = rule[W_DST_MASK*DW +: IP_ADDR_LEN];
   assign rule_src_port = rule[W_PORTS*DW + 16 +: PORT_LEN];
   assign rule_dst_port = rule[W_PORTS*DW +: PORT_LEN];

   // A zero mask makes both sides zero, so the address compares equal for any header.
   assign src_ok   = (src_ip & src_mask) == (rule_src_ip & src_mask);
   assign dst_ok   = (dst_ip & dst_mask) == (rule_dst_ip & dst_mask);
   assign sport_ok = ctrl[CTRL_SPW] || (src_port == rule_src_port);
   assign dport_ok = ctrl[CTRL_DPW] || (dst_port == rule_dst_port);
   assign proto_ok = ctrl[CTRL_PRW] || (proto == ctrl[CTRL_PROTO_LSB +: 8]);

   assign hit = ctrl[CTRL_EN] && src_ok && dst_ok && sport_ok && dport_ok && proto_ok;

   assign unused_ctrl_bits = ^{ctrl[DW-1:CTRL_PROTO_LSB+8], ctrl[CTRL_PROTO_LSB-1:CTRL_PRW+1], ctrl[CTRL_ACT]};

endmodule

// File: rtl/filter_rule_engine.sv
// Prioritised masked 5-tuple filter: IDLE -> MATCH -> RESOLVE -> HOLD, with per-rule and miss hit counters.
module filter_rule_engine
   import filter_pkg::*;
#(
   parameter int NUM_RULES          = 8,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter bit DEFAULT_ACTION     = 1'b1,
   parameter int IP_ADDR_LEN        = 32,
   parameter int PORT_LEN           = 16
) (
   input  logic                                                axi_aclk,
   input  logic                                                axi_aresetn,
   filter_rule_engine_if.slave                                 hdr_bus,
   input  logic                                                cnt_clear,
   input  logic [NUM_RULES*RULE_WORDS*C_S_AXI_DATA_WIDTH-1:0]  rw_regs,
   output logic [NUM_RULES*RULE_WORDS*C_S_AXI_DATA_WIDTH-1:0]  rw_defaults,
   output logic [(NUM_RULES+1)*C_S_AXI_DATA_WIDTH-1:0]         ro_regs
);
   localparam int DW         = C_S_AXI_DATA_WIDTH;
   localparam int RULE_BITS  = RULE_WORDS*DW;
   localparam int TABLE_BITS = NUM_RULES*RULE_BITS;

   state_t                 state_q, state_d;
   logic                   latch_en, match_en, resolve_en, release_en;
   logic [TABLE_BITS-1:0]  shadow_q;
   logic [IP_ADDR_LEN-1:0] src_ip_q, dst_ip_q;
   logic [PORT_LEN-1:0]    src_port_q, dst_port_q;
   logic [7:0]             proto_q;
   logic [NUM_RULES-1:0]   match_d, match_q, act_vec;
   logic [NUM_RULES:0]     sel;
   logic                   hit_any;
   logic                   send_q, send_rd_q;

   assign rw_defaults       = '0;
   assign hdr_bus.m_send    = send_q;
   assign hdr_bus.m_send_rd = send_rd_q;

   // NOTE: every clocked process uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   // NOTE: each combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (hdr_bus.hdr_rd) state_d = ST_MATCH;
         ST_MATCH:   state_d = ST_RESOLVE;
         ST_RESOLVE: state_d = ST_HOLD;
         ST_HOLD:    if (hdr_bus.hdr_clear) state_d = hdr_bus.hdr_rd ? ST_MATCH : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      latch_en   = 1'b0;
      match_en   = 1'b0;
      resolve_en = 1'b0;
      release_en = 1'b0;
      case (state_q)
         ST_IDLE:    latch_en = hdr_bus.hdr_rd;
         ST_MATCH:   match_en = 1'b1;
         ST_RESOLVE: resolve_en = 1'b1;
         ST_HOLD: begin
            release_en = hdr_bus.hdr_clear;
            latch_en   = hdr_bus.hdr_clear & hdr_bus.hdr_rd;
         end
         default: ;
      endcase
   end

   // NOTE: the shadow table is a flop bank, not a RAM, so it is cleared by the async reset like any other state.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         shadow_q   <= '0;
         src_ip_q   <= '0;
         dst_ip_q   <= '0;
         src_port_q <= '0;
         dst_port_q <= '0;
         proto_q    <= '0;
         match_q    <= '0;
         send_q     <= 1'b0;
         send_rd_q  <= 1'b0;
      end else begin
         if (latch_en) begin
            shadow_q   <= rw_regs;
            src_ip_q   <= hdr_bus.hdr_src_ip[IP_ADDR_LEN-1:0];
            dst_ip_q   <= hdr_bus.hdr_dst_ip[IP_ADDR_LEN-1:0];
            src_port_q <= hdr_bus.hdr_src_port[PORT_LEN-1:0];
            dst_port_q <= hdr_bus.hdr_dst_port[PORT_LEN-1:0];
            proto_q    <= hdr_bus.hdr_proto;
         end
         if (match_en) match_q <= match_d;
         if (resolve_en) begin
            send_q    <= hit_any ? |(sel[NUM_RULES-1:0] & act_vec) : DEFAULT_ACTION;
            send_rd_q <= 1'b1;
         end else if (release_en) begin
            send_rd_q <= 1'b0;
         end
      end
   end

   for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
      filter_rule_match #(
         .DW          (DW),
         .IP_ADDR_LEN (IP_ADDR_LEN),
         .PORT_LEN    (PORT_LEN)
      ) u_match (
         .rule     (shadow_q[r*RULE_BITS +: RULE_BITS]),
         .src_ip   (src_ip_q),
         .dst_ip   (dst_ip_q),
         .src_port (src_port_q),
         .dst_port (dst_port_q),
         .proto    (proto_q),
         .hit      (match_d[r])
      );
      assign act_vec[r] = shadow_q[r*RULE_BITS + W_CTRL*DW + CTRL_ACT];
   end

   // One-hot select: lowest matching rule wins; the extra top bit selects the miss counter.
   always_comb begin
      sel     = '0;
      hit_any = 1'b0;
      for (int r = 0; r < NUM_RULES; r++) begin
         if (match_q[r] && !hit_any) begin
            sel[r]  = 1'b1;
            hit_any = 1'b1;
         end
      end
      sel[NUM_RULES] = ~hit_any;
   end

   for (genvar i = 0; i <= NUM_RULES; i++) begin : g_cnt
      logic [DW-1:0] cnt;
      always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
         if (!axi_aresetn)                             cnt <= '0;
         else if (cnt_clear)                           cnt <= '0;
         else if (resolve_en && sel[i] && cnt != '1)   cnt <= cnt + DW'(1);
      end
      assign ro_regs[i*DW +: DW] = cnt;
   end

endmodule
